// File: rtl/uart_fifo_pkg.sv
// Shared defaults and width helpers for the parametrised UART byte FIFO.
package uart_fifo_pkg;

   localparam int DEF_DATA_SIZE = 8;
   localparam int DEF_DEPTH     = 16;
   localparam int DEF_AF_LEVEL  = 12;
   localparam int DEF_AE_LEVEL  = 2;

   // Ceiling log2; clog2(1) = 0.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result = result + 1;
      end
      return result;
   endfunction

   localparam int ADDR_WIDTH = clog2(DEF_DEPTH);
   localparam int CNT_WIDTH  = clog2(DEF_DEPTH + 1);

endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO storage: one synchronous write port and an asynchronous read port.
module uart_fifo_mem #(
   parameter int DATA_SIZE = 8,
   parameter int DEPTH     = 16,
   parameter int AW        = 4
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [AW-1:0]        waddr,
   input  logic [DATA_SIZE-1:0] wdata,
   input  logic [AW-1:0]        raddr,
   output logic [DATA_SIZE-1:0] rdata
);

   logic [DATA_SIZE-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   assign rdata = r_mem[raddr];

endmodule

// File: rtl/uart_fifo_lvl.sv
// Show-ahead UART FIFO with occupancy count, almost-full/empty levels and flush.
// Sticky overflow/underflow flags exist only when UART_FIFO_ERR_FLAGS_EN is defined.
module uart_fifo_lvl
   import uart_fifo_pkg::*;
#(
   parameter int DATA_SIZE = DEF_DATA_SIZE,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int AF_LEVEL  = DEF_AF_LEVEL,
   parameter int AE_LEVEL  = DEF_AE_LEVEL
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        s_tick,
   input  logic                        flush,
   input  logic [DATA_SIZE-1:0]        w_data,
   input  logic                        wr,
   input  logic                        rd,
   output logic [DATA_SIZE-1:0]        r_data,
   output logic                        full,
   output logic                        empty,
   output logic                        almost_full,
   output logic                        almost_empty,
   output logic [clog2(DEPTH+1)-1:0]   count,
   output logic                        overflow,
   output logic                        underflow
);

   localparam int AW = clog2(DEPTH);
   localparam int CW = clog2(DEPTH + 1);

   logic [AW-1:0]        r_w_ptr;
   logic [AW-1:0]        r_r_ptr;
   logic [CW-1:0]        r_count;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_do_wr;
   logic                 w_do_rd;
   logic [DATA_SIZE-1:0] w_rdata;

   // Explicit wrap at DEPTH-1 so non-power-of-two depths work.
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);

   // A write into a full FIFO is accepted only when a read frees the head slot.
   assign w_do_wr = s_tick & wr & (~w_full | rd);
   assign w_do_rd = s_tick & rd & ~w_empty;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_w_ptr <= '0;
         r_r_ptr <= '0;
         r_count <= '0;
      end else begin
         if (w_do_wr) begin
            r_w_ptr <= ptr_inc(r_w_ptr);
         end
         if (w_do_rd) begin
            r_r_ptr <= ptr_inc(r_r_ptr);
         end
         if (w_do_wr && !w_do_rd) begin
            r_count <= r_count + 1'b1;
         end else if (w_do_rd && !w_do_wr) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   uart_fifo_mem #(
      .DATA_SIZE (DATA_SIZE),
      .DEPTH     (DEPTH),
      .AW        (AW)
   ) u_mem (
      .clk   (clk),
      .we    (w_do_wr),
      .waddr (r_w_ptr),
      .wdata (w_data),
      .raddr (r_r_ptr),
      .rdata (w_rdata)
   );

   assign r_data       = w_empty ? '0 : w_rdata;
   assign full         = w_full;
   assign empty        = w_empty;
   assign almost_full  = (r_count >= CW'(AF_LEVEL));
   assign almost_empty = (r_count <= CW'(AE_LEVEL));
   assign count        = r_count;

`ifdef UART_FIFO_ERR_FLAGS_EN
   logic r_overflow;
   logic r_underflow;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (s_tick && wr && w_full && !rd) begin
            r_overflow <= 1'b1;
         end
         if (s_tick && rd && w_empty && !wr) begin
            r_underflow <= 1'b1;
         end
      end
   end

   assign overflow  = r_overflow;
   assign underflow = r_underflow;
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_uart_fifo_lvl.sv
// Scoreboard bench for uart_fifo_lvl: default instance plus a DEPTH=5 instance.
module tb_uart_fifo_lvl;

`ifdef UART_FIFO_ERR_FLAGS_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   int         checks = 0;
   int         failures = 0;

   // default instance (DEPTH 16, AF 12, AE 2)
   logic       s_tick, flush, wr, rd;
   logic [7:0] w_data, r_data;
   logic       full, empty, almost_full, almost_empty, overflow, underflow;
   logic [4:0] count;
   logic [7:0] exp_q[$];

   // DEPTH 5 instance (AF 4, AE 1)
   logic       s_tick5, flush5, wr5, rd5;
   logic [7:0] w_data5, r_data5;
   logic       full5, empty5, almost_full5, almost_empty5, overflow5, underflow5;
   logic [2:0] count5;
   logic [7:0] exp5_q[$];
   int         max_count5 = 0;

   always #5 clk = ~clk;

   uart_fifo_lvl u_dut (
      .clk(clk), .reset(reset), .s_tick(s_tick), .flush(flush), .w_data(w_data),
      .wr(wr), .rd(rd), .r_data(r_data), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
      .overflow(overflow), .underflow(underflow)
   );

   uart_fifo_lvl #(.DATA_SIZE(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) u_dut5 (
      .clk(clk), .reset(reset), .s_tick(s_tick5), .flush(flush5), .w_data(w_data5),
      .wr(wr5), .rd(rd5), .r_data(r_data5), .full(full5), .empty(empty5),
      .almost_full(almost_full5), .almost_empty(almost_empty5), .count(count5),
      .overflow(overflow5), .underflow(underflow5)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step0(input logic t, input logic w, input logic r, input logic [7:0] d);
      s_tick = t; wr = w; rd = r; w_data = d;
      @(posedge clk); #1;
   endtask

   task automatic step5(input logic t, input logic w, input logic r, input logic [7:0] d);
      s_tick5 = t; wr5 = w; rd5 = r; w_data5 = d;
      @(posedge clk); #1;
   endtask

   task automatic chk_reset_state();
      chk("rst_count", 32'(count), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_ae", 32'(almost_empty), 1);
      chk("rst_af", 32'(almost_full), 0);
      chk("rst_rdata", 32'(r_data), 0);
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_unf", 32'(underflow), 0);
   endtask

   // Monitors: a pop is presented whenever an accepted read is about to clock.
   always @(negedge clk) begin
      if (!reset && !flush && s_tick && rd && !empty) begin
         if (exp_q.size() == 0) begin
            chk("pop_unexpected", 32'(r_data), 32'hFFFF_FFFF);
         end else begin
            chk("pop_data", 32'(r_data), 32'(exp_q.pop_front()));
         end
      end
   end

   always @(negedge clk) begin
      if (!reset && !flush5 && s_tick5 && rd5 && !empty5) begin
         if (exp5_q.size() == 0) begin
            chk("pop5_unexpected", 32'(r_data5), 32'hFFFF_FFFF);
         end else begin
            chk("pop5_data", 32'(r_data5), 32'(exp5_q.pop_front()));
         end
      end
      if (int'(count5) > max_count5) max_count5 = int'(count5);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      s_tick = 0; flush = 0; wr = 0; rd = 0; w_data = 0;
      s_tick5 = 0; flush5 = 0; wr5 = 0; rd5 = 0; w_data5 = 0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_state();
      reset = 1'b0;

      // 1: fill 0x01..0x10, then an overflowing write
      for (int i = 1; i <= 16; i++) begin
         exp_q.push_back(8'(i));
         step0(1, 1, 0, 8'(i));
         chk("fill_count", 32'(count), 32'(i));
         chk("fill_af", 32'(almost_full), (i >= 12) ? 1 : 0);
      end
      chk("fill_full", 32'(full), 1);
      step0(1, 1, 0, 8'hFF);
      chk("ovf_count", 32'(count), 16);
      chk("ovf_flag", 32'(overflow), 32'(ERR_EN));
      chk("ovf_head", 32'(r_data), 32'h01);

      // 2: drain, then an underflowing read
      for (int k = 1; k <= 16; k++) begin
         step0(1, 0, 1, 8'h00);
         chk("drain_count", 32'(count), 32'(16 - k));
         chk("drain_ae", 32'(almost_empty), (16 - k <= 2) ? 1 : 0);
      end
      chk("drain_empty", 32'(empty), 1);
      chk("drain_rdata", 32'(r_data), 0);
      step0(1, 0, 1, 8'h00);
      chk("unf_flag", 32'(underflow), 32'(ERR_EN));
      chk("unf_count", 32'(count), 0);
      flush = 1'b1;
      step0(0, 0, 0, 8'h00);
      flush = 1'b0;
      chk("flush_ovf", 32'(overflow), 0);
      chk("flush_unf", 32'(underflow), 0);

      // 4: wr&rd on empty, then wr&rd on full
      exp_q.push_back(8'hA5);
      step0(1, 1, 1, 8'hA5);
      chk("wrrd_empty_count", 32'(count), 1);
      chk("wrrd_empty_rdata", 32'(r_data), 32'hA5);
      chk("wrrd_empty_unf", 32'(underflow), 0);
      for (int i = 1; i <= 15; i++) begin
         exp_q.push_back(8'(8'h20 + i));
         step0(1, 1, 0, 8'(8'h20 + i));
      end
      chk("wrrd_full_pre", 32'(full), 1);
      exp_q.push_back(8'h3C);
      step0(1, 1, 1, 8'h3C);
      chk("wrrd_full_count", 32'(count), 16);
      chk("wrrd_full_head", 32'(r_data), 32'h21);
      chk("wrrd_full_ovf", 32'(overflow), 0);
      for (int k = 0; k < 16; k++) step0(1, 0, 1, 8'h00);
      chk("wrrd_full_drained", 32'(count), 0);

      // 5: s_tick low holds state, then flush without s_tick
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(8'(8'h60 + i));
         step0(1, 1, 0, 8'(8'h60 + i));
      end
      for (int i = 0; i < 10; i++) step0(0, 1, 1, 8'h77);
      chk("hold_count", 32'(count), 3);
      chk("hold_head", 32'(r_data), 32'h60);
      flush = 1'b1;
      exp_q.delete();
      step0(0, 1, 1, 8'h77);
      flush = 1'b0;
      chk("flush_count", 32'(count), 0);
      chk("flush_empty", 32'(empty), 1);
      chk("flush_rdata", 32'(r_data), 0);
      chk("flush_ovf2", 32'(overflow), 0);
      step0(0, 0, 0, 8'h00);

      // 3: DEPTH 5, two words ahead, 12 wr&rd pairs across the pointer wrap
      for (int i = 0; i < 2; i++) begin
         exp5_q.push_back(8'(8'h40 + i));
         step5(1, 1, 0, 8'(8'h40 + i));
      end
      for (int i = 2; i < 14; i++) begin
         exp5_q.push_back(8'(8'h40 + i));
         step5(1, 1, 1, 8'(8'h40 + i));
         chk("d5_pair_count", 32'(count5), 2);
      end
      for (int i = 0; i < 3; i++) begin
         exp5_q.push_back(8'(8'h50 + i));
         step5(1, 1, 0, 8'(8'h50 + i));
      end
      chk("d5_full", 32'(full5), 1);
      chk("d5_count", 32'(count5), 5);
      chk("d5_af", 32'(almost_full5), 1);
      step5(1, 1, 0, 8'hEE);
      chk("d5_ovf_count", 32'(count5), 5);
      for (int k = 0; k < 5; k++) step5(1, 0, 1, 8'h00);
      chk("d5_empty", 32'(empty5), 1);
      chk("d5_max_count", 32'(max_count5), 5);
      step5(0, 0, 0, 8'h00);

      // 6: reset in the middle of a wr&rd burst
      exp_q.push_back(8'h11);
      step0(1, 1, 0, 8'h11);
      exp_q.push_back(8'h12);
      step0(1, 1, 0, 8'h12);
      exp_q.push_back(8'h13);
      step0(1, 1, 1, 8'h13);
      reset = 1'b1;
      exp_q.delete();
      step0(1, 1, 1, 8'h14);
      reset = 1'b0;
      chk_reset_state();
      exp_q.push_back(8'h5A);
      step0(1, 1, 0, 8'h5A);
      chk("post_rst_count", 32'(count), 1);
      chk("post_rst_rdata", 32'(r_data), 32'h5A);
      step0(1, 0, 1, 8'h00);
      step0(0, 0, 0, 8'h00);

      chk("sb_left", 32'(exp_q.size()), 0);
      chk("sb5_left", 32'(exp5_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
